// File: rtl/turn_switch_n.sv
// N-player chess-clock turn arbiter: one-hot timer enable, pause/resume, sticky game-over.
// Optional move counter is built when TURN_SWITCH_MOVE_COUNT_EN is defined.
module turn_switch_n #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned FIRST_PLAYER = 0,
  parameter int unsigned MOVE_W       = 10,
  localparam int unsigned IDX_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   CE,
  input  logic                   START,
  input  logic                   STOP,
  input  logic                   END,
  input  logic [NUM_PLAYERS-1:0] PRESS,
  output logic [NUM_PLAYERS-1:0] ENABLE,
  output logic [IDX_W-1:0]       ACTIVE,
  output logic                   TURN_CHG,
  output logic                   OVER,
  output logic [IDX_W-1:0]       LOSER,
  output logic [MOVE_W-1:0]      MOVES
);

  localparam logic [IDX_W-1:0] FirstIdx = IDX_W'(FIRST_PLAYER);
  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e                 state_q;
  logic [NUM_PLAYERS-1:0] press_q;
  logic [NUM_PLAYERS-1:0] pe;
  logic [NUM_PLAYERS-1:0] enable_q;
  logic [IDX_W-1:0]       active_q;
  logic [IDX_W-1:0]       active_nxt;
  logic [IDX_W-1:0]       loser_q;
  logic                   turn_chg_q;
  logic                   over_q;
  logic                   accept;

  function automatic logic [NUM_PLAYERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_PLAYERS'(1) << idx;
  endfunction

  assign pe         = PRESS & ~press_q;
  // END and STOP both outrank a press in the same cycle.
  assign accept     = CE && (state_q == StRun) && !END && !STOP && (|(pe & onehot(active_q)));
  assign active_nxt = (active_q == LastIdx) ? '0 : active_q + IDX_W'(1);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= StIdle;
      press_q    <= '0;
      enable_q   <= '0;
      active_q   <= FirstIdx;
      turn_chg_q <= 1'b0;
      over_q     <= 1'b0;
      loser_q    <= '0;
    end else begin
      // Single-cycle pulse; clears even when CE is low.
      turn_chg_q <= accept;
      if (CE) begin
        press_q <= PRESS;
        unique case (state_q)
          StIdle: begin
            if (START && !STOP && !END) begin
              state_q  <= StRun;
              enable_q <= onehot(active_q);
            end
          end
          StRun: begin
            if (END) begin
              state_q  <= StDone;
              enable_q <= '0;
              over_q   <= 1'b1;
              loser_q  <= active_q;
            end else if (STOP) begin
              state_q  <= StPause;
              enable_q <= '0;
            end else if (accept) begin
              active_q <= active_nxt;
              enable_q <= onehot(active_nxt);
            end
          end
          StPause: begin
            if (END) begin
              state_q <= StDone;
              over_q  <= 1'b1;
              loser_q <= active_q;
            end else if (!STOP) begin
              state_q  <= StRun;
              enable_q <= onehot(active_q);
            end
          end
          StDone: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ENABLE   = enable_q;
  assign ACTIVE   = active_q;
  assign TURN_CHG = turn_chg_q;
  assign OVER     = over_q;
  assign LOSER    = loser_q;

`ifdef TURN_SWITCH_MOVE_COUNT_EN
  logic [MOVE_W-1:0] moves_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      moves_q <= '0;
    end else if (accept && (moves_q != '1)) begin
      moves_q <= moves_q + MOVE_W'(1);
    end
  end

  assign MOVES = moves_q;
`else
  assign MOVES = '0;
`endif

endmodule

// File: tb/tb_turn_switch_n.sv
// Bench for turn_switch_n (3 players, 3-bit move counter): per-cycle model compare plus
// directed scenarios with literal expectations. Honours TURN_SWITCH_MOVE_COUNT_EN.
module tb_turn_switch_n;
  localparam int NP = 3;
  localparam int MW = 3;
`ifdef TURN_SWITCH_MOVE_COUNT_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic          CLK = 1'b0, CLR = 1'b0, CE = 1'b1, START = 1'b0, STOP = 1'b0, END = 1'b0;
  logic [NP-1:0] PRESS = '0;
  logic [NP-1:0] ENABLE;
  logic [1:0]    ACTIVE, LOSER;
  logic          TURN_CHG, OVER;
  logic [MW-1:0] MOVES;

  int checks = 0;
  int errors = 0;

  turn_switch_n #(.NUM_PLAYERS(NP), .FIRST_PLAYER(0), .MOVE_W(MW)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .STOP(STOP), .END(END), .PRESS(PRESS),
    .ENABLE(ENABLE), .ACTIVE(ACTIVE), .TURN_CHG(TURN_CHG), .OVER(OVER), .LOSER(LOSER),
    .MOVES(MOVES)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: game phase 0=idle 1=run 2=pause 3=done, player index kept as a plain integer.
  int            m_st, m_act, m_loser, m_moves;
  bit            m_tc, m_over, hit;
  logic [NP-1:0] m_prev;

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      m_st = 0; m_act = 0; m_loser = 0; m_moves = 0; m_tc = 0; m_over = 0; m_prev = '0;
    end else begin
      hit  = CE && PRESS[m_act] && !m_prev[m_act];
      m_tc = 0;
      if (CE) begin
        m_prev = PRESS;
        case (m_st)
          0: if (START && !STOP && !END) m_st = 1;
          1: begin
            if (END) begin m_st = 3; m_over = 1; m_loser = m_act; end
            else if (STOP) m_st = 2;
            else if (hit) begin
              m_act = (m_act + 1) % NP;
              m_tc  = 1;
              if (MC && m_moves < (2 ** MW) - 1) m_moves++;
            end
          end
          2: begin
            if (END) begin m_st = 3; m_over = 1; m_loser = m_act; end
            else if (!STOP) m_st = 1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (!CLR) begin
      chk("m_enable", 32'(ENABLE), (m_st == 1) ? (32'd1 << m_act) : 32'd0);
      chk("m_active", 32'(ACTIVE), 32'(m_act));
      chk("m_turn_chg", 32'(TURN_CHG), 32'(m_tc));
      chk("m_over", 32'(OVER), 32'(m_over));
      chk("m_loser", 32'(LOSER), 32'(m_loser));
      chk("m_moves", 32'(MOVES), 32'(m_moves));
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic press(input int i);
    PRESS[i] = 1'b1;
    step();
    PRESS[i] = 1'b0;
    step();
  endtask

  initial begin
    #1 CLR = 1'b1;
    step(); step();
    chk("rst_enable", 32'(ENABLE), 0);
    chk("rst_active", 32'(ACTIVE), 0);
    chk("rst_turn_chg", 32'(TURN_CHG), 0);
    chk("rst_over", 32'(OVER), 0);
    chk("rst_loser", 32'(LOSER), 0);
    chk("rst_moves", 32'(MOVES), 0);

    CLR = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    chk("start_enable", 32'(ENABLE), 32'b001);

    PRESS[0] = 1'b1;
    step();
    chk("first_tc", 32'(TURN_CHG), 1);
    chk("first_handover", 32'(ENABLE), 32'b010);
    chk("first_moves", 32'(MOVES), MC ? 1 : 0);
    PRESS[0] = 1'b0;
    step();
    chk("tc_clear", 32'(TURN_CHG), 0);

    press(1); press(2); press(0);
    chk("wrap_active", 32'(ACTIVE), 1);
    chk("four_moves", 32'(MOVES), MC ? 4 : 0);
    press(2);
    chk("nonactive_ignored", 32'(ACTIVE), 1);

    PRESS[1] = 1'b1;
    repeat (10) step();
    PRESS[1] = 1'b0;
    step();
    chk("held_single", 32'(ACTIVE), 2);
    chk("held_moves", 32'(MOVES), MC ? 5 : 0);

    press(2); press(0);
    STOP = 1'b1;
    step();
    chk("pause_enable", 32'(ENABLE), 0);
    press(1);
    chk("pause_ignores", 32'(ACTIVE), 1);
    STOP = 1'b0;
    step();
    chk("resume_enable", 32'(ENABLE), 32'b010);

    STOP = 1'b1; PRESS[1] = 1'b1;
    step();
    chk("stop_wins", 32'(ACTIVE), 1);
    STOP = 1'b0; PRESS[1] = 1'b0;
    step();

    press(1);
    chk("sat_moves", 32'(MOVES), MC ? 7 : 0);
    chk("pre_end_active", 32'(ACTIVE), 2);

    END = 1'b1; PRESS[2] = 1'b1;
    step();
    chk("end_over", 32'(OVER), 1);
    chk("end_loser", 32'(LOSER), 2);
    chk("end_enable", 32'(ENABLE), 0);
    chk("end_no_tc", 32'(TURN_CHG), 0);
    END = 1'b0; PRESS[2] = 1'b0; START = 1'b1;
    step(); step();
    chk("done_start_over", 32'(OVER), 1);
    chk("done_start_enable", 32'(ENABLE), 0);
    START = 1'b0;

    CLR = 1'b1;
    #1 chk("clr_done_over", 32'(OVER), 0);
    step();
    CLR = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    press(0);
    chk("restart_active", 32'(ACTIVE), 1);
    #1 CLR = 1'b1;
    #1;
    chk("async_active", 32'(ACTIVE), 0);
    chk("async_enable", 32'(ENABLE), 0);
    chk("async_moves", 32'(MOVES), 0);
    step();
    CLR = 1'b0; START = 1'b1;
    step();
    START = 1'b0;

    // Edge that lives only inside a CE=0 window must be lost.
    CE = 1'b0; PRESS[0] = 1'b1;
    step();
    PRESS[0] = 1'b0;
    step();
    CE = 1'b1;
    step();
    chk("ce_missed", 32'(ACTIVE), 0);
    CE = 1'b0;
    step(); step(); step();
    CE = 1'b1; PRESS[0] = 1'b1;
    step();
    chk("ce_accept", 32'(ACTIVE), 1);
    chk("ce_accept_tc", 32'(TURN_CHG), 1);
    CE = 1'b0; PRESS[0] = 1'b0;
    step();
    chk("ce_tc_clear", 32'(TURN_CHG), 0);
    chk("ce_hold", 32'(ACTIVE), 1);

    for (int k = 0; k < 36; k++) begin
      CE    = (k % 4 == 3);
      PRESS = ((k / 5) % 2 == 1) ? 3'b111 : 3'b000;
      step();
    end
    CE = 1'b1; PRESS = '0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
